// File: rtl/hazard_tracker_if.sv
// Pipeline hazard interface: decode-stage instruction metadata and the
// execute-stage redirect flowing into the tracker, forward selects,
// stall/flush controls and perf counters flowing back out.
interface hazard_tracker_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_CNT_W = 32
);
    logic [REG_ADDR_W-1:0] iRs1D;
    logic [REG_ADDR_W-1:0] iRs2D;
    logic [REG_ADDR_W-1:0] iRdD;
    logic                  iRegWriteD;
    logic                  iIsLoadD;
    logic                  iIsUpperD;
    logic                  iPcSrcE;
    logic [1:0]            oForwardAluOp1E;
    logic [1:0]            oForwardAluOp2E;
    logic                  oStallF;
    logic                  oStallD;
    logic                  oFlushD;
    logic                  oFlushE;
    logic [PERF_CNT_W-1:0] oStallCnt;
    logic [PERF_CNT_W-1:0] oFlushCnt;

    // Pipeline side: presents the decoded instruction and branch outcome
    modport master (
        output iRs1D, iRs2D, iRdD, iRegWriteD, iIsLoadD, iIsUpperD, iPcSrcE,
        input  oForwardAluOp1E, oForwardAluOp2E, oStallF, oStallD,
               oFlushD, oFlushE, oStallCnt, oFlushCnt
    );

    // Tracker side
    modport slave (
        input  iRs1D, iRs2D, iRdD, iRegWriteD, iIsLoadD, iIsUpperD, iPcSrcE,
        output oForwardAluOp1E, oForwardAluOp2E, oStallF, oStallD,
               oFlushD, oFlushE, oStallCnt, oFlushCnt
    );
endinterface

// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks destination-register metadata for the E, M and W
// stages, produces E-stage operand forward selects, detects load-use hazards
// and taken-branch redirects, and drives the stall/flush controls.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters;
// without it the counter outputs are constant zero.
module hazard_tracker #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_tracker_if.slave  bus
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regWrite;
        logic                  isLoad;
        logic                  isUpper;
    } eSlot_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  regWrite;
        logic                  isUpper;
    } mwSlot_t;

    eSlot_t  eSlot_q, eSlot_d;
    mwSlot_t mSlot_q, wSlot_q;

    logic loadUse;
    logic redirect;
    logic stallTaken;
    logic flushE;

    // Forward select for one operand: nearest writer wins, and an upper-type
    // producer routes through the immediate path regardless of its stage.
    function automatic logic [1:0] forwardSel(
        input logic [REG_ADDR_W-1:0] rsE,
        input mwSlot_t               m,
        input mwSlot_t               w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rsE != '0) begin
            if (m.regWrite && m.rd == rsE) begin
                sel = m.isUpper ? 2'b11 : 2'b01;
            end else if (w.regWrite && w.rd == rsE) begin
                sel = w.isUpper ? 2'b11 : 2'b10;
            end
        end
        return sel;
    endfunction

    // Hazard detection and stall/flush control; a redirect discards the
    // decode instruction, so it overrides any load-use stall.
    always_comb begin
        loadUse    = eSlot_q.isLoad && eSlot_q.regWrite && (eSlot_q.rd != '0) &&
                     ((eSlot_q.rd == bus.iRs1D) || (eSlot_q.rd == bus.iRs2D));
        redirect   = bus.iPcSrcE;
        stallTaken = loadUse && !redirect;
        flushE     = loadUse || redirect;
    end

    assign bus.oStallF         = stallTaken;
    assign bus.oStallD         = stallTaken;
    assign bus.oFlushD         = redirect;
    assign bus.oFlushE         = flushE;
    assign bus.oForwardAluOp1E = forwardSel(eSlot_q.rs1, mSlot_q, wSlot_q);
    assign bus.oForwardAluOp2E = forwardSel(eSlot_q.rs2, mSlot_q, wSlot_q);

    // Next E-slot contents: the decode instruction, or a bubble when flushed
    always_comb begin
        eSlot_d = '0;
        if (!flushE) begin
            eSlot_d.rs1      = bus.iRs1D;
            eSlot_d.rs2      = bus.iRs2D;
            eSlot_d.rd       = bus.iRdD;
            eSlot_d.regWrite = bus.iRegWriteD;
            eSlot_d.isLoad   = bus.iIsLoadD;
            eSlot_d.isUpper  = bus.iIsUpperD;
        end
    end

    // Advance the E -> M -> W metadata shift register every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eSlot_q <= '0;
            mSlot_q <= '0;
            wSlot_q <= '0;
        end else begin
            eSlot_q          <= eSlot_d;
            mSlot_q.rd       <= eSlot_q.rd;
            mSlot_q.regWrite <= eSlot_q.regWrite;
            mSlot_q.isUpper  <= eSlot_q.isUpper;
            wSlot_q          <= mSlot_q;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [PERF_CNT_W-1:0] CntOne = PERF_CNT_W'(1);

    logic [PERF_CNT_W-1:0] stallCnt_q;
    logic [PERF_CNT_W-1:0] flushCnt_q;

    // Saturating counters of taken load-use stalls and redirect flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (stallTaken && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + CntOne;
            end
            if (redirect && (flushCnt_q != '1)) begin
                flushCnt_q <= flushCnt_q + CntOne;
            end
        end
    end

    assign bus.oStallCnt = stallCnt_q;
    assign bus.oFlushCnt = flushCnt_q;
`else
    assign bus.oStallCnt = {PERF_CNT_W{1'b0}};
    assign bus.oFlushCnt = {PERF_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed instruction sequences with
// literal expectations, plus an age-ordered in-flight instruction model
// checked against every output on each falling clock edge.
module tb_hazard_tracker;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       up;
    } instr_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    hazard_tracker_if #(.REG_ADDR_W(5), .PERF_CNT_W(32)) bus ();

    hazard_tracker #(.REG_ADDR_W(5), .PERF_CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-flight instructions by age: 0 = in E, 1 = one ahead (M), 2 = two ahead (W)
    instr_t      hist [3];
    logic [31:0] expStallCnt;
    logic [31:0] expFlushCnt;

    function automatic instr_t mk(input int rs1, input int rs2, input int rd,
                                  input bit rw, input bit ld, input bit up);
        instr_t i;
        i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd);
        i.rw = rw; i.ld = ld; i.up = up;
        return i;
    endfunction

    function automatic instr_t currentD();
        instr_t i;
        i.rs1 = bus.iRs1D; i.rs2 = bus.iRs2D; i.rd = bus.iRdD;
        i.rw = bus.iRegWriteD; i.ld = bus.iIsLoadD; i.up = bus.iIsUpperD;
        return i;
    endfunction

    // Youngest older writer of rs decides; upper producers use the imm path
    function automatic logic [1:0] expFwd(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            for (int age = 2; age >= 1; age--) begin
                if (hist[age].rw && hist[age].rd == rs)
                    sel = hist[age].up ? 2'b11 : 2'(age);
            end
        end
        return sel;
    endfunction

    function automatic logic expLoadUse();
        return hist[0].ld && hist[0].rw && (hist[0].rd != 5'd0) &&
               ((hist[0].rd == bus.iRs1D) || (hist[0].rd == bus.iRs2D));
    endfunction

    function automatic logic expStall();
        return expLoadUse() && !bus.iPcSrcE;
    endfunction

    function automatic logic expFlushE();
        return expLoadUse() || bus.iPcSrcE;
    endfunction

    // Model advance on each rising edge; reset empties the pipeline
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist[0]     <= mk(0, 0, 0, 0, 0, 0);
            hist[1]     <= mk(0, 0, 0, 0, 0, 0);
            hist[2]     <= mk(0, 0, 0, 0, 0, 0);
            expStallCnt <= 32'd0;
            expFlushCnt <= 32'd0;
        end else begin
            hist[0] <= expFlushE() ? mk(0, 0, 0, 0, 0, 0) : currentD();
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            if (expStall() && expStallCnt != 32'hFFFF_FFFF)
                expStallCnt <= expStallCnt + 32'd1;
            if (bus.iPcSrcE && expFlushCnt != 32'hFFFF_FFFF)
                expFlushCnt <= expFlushCnt + 32'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every mid-cycle point: all outputs against the model
    always @(negedge clk) begin
        checkOutput("model_fwd1", 32'(bus.oForwardAluOp1E), 32'(expFwd(hist[0].rs1)));
        checkOutput("model_fwd2", 32'(bus.oForwardAluOp2E), 32'(expFwd(hist[0].rs2)));
        checkOutput("model_stallF", 32'(bus.oStallF), 32'(expStall()));
        checkOutput("model_stallD", 32'(bus.oStallD), 32'(expStall()));
        checkOutput("model_flushD", 32'(bus.oFlushD), 32'(bus.iPcSrcE));
        checkOutput("model_flushE", 32'(bus.oFlushE), 32'(expFlushE()));
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("model_stallCnt", bus.oStallCnt, expStallCnt);
        checkOutput("model_flushCnt", bus.oFlushCnt, expFlushCnt);
`else
        checkOutput("model_stallCnt", bus.oStallCnt, 32'd0);
        checkOutput("model_flushCnt", bus.oFlushCnt, 32'd0);
`endif
    end

    task automatic driveD(input instr_t ins, input logic pcSrc);
        bus.iRs1D      = ins.rs1;
        bus.iRs2D      = ins.rs2;
        bus.iRdD       = ins.rd;
        bus.iRegWriteD = ins.rw;
        bus.iIsLoadD   = ins.ld;
        bus.iIsUpperD  = ins.up;
        bus.iPcSrcE    = pcSrc;
    endtask

    // Present one instruction in D for a full cycle, return at mid-cycle
    task automatic applyStimulus(input instr_t ins, input logic pcSrc);
        @(posedge clk);
        #1;
        driveD(ins, pcSrc);
        @(negedge clk);
    endtask

    task automatic checkAllQuiet(input string tag);
        checkOutput({tag, "_fwd1"}, 32'(bus.oForwardAluOp1E), 32'd0);
        checkOutput({tag, "_fwd2"}, 32'(bus.oForwardAluOp2E), 32'd0);
        checkOutput({tag, "_stallF"}, 32'(bus.oStallF), 32'd0);
        checkOutput({tag, "_stallD"}, 32'(bus.oStallD), 32'd0);
        checkOutput({tag, "_flushD"}, 32'(bus.oFlushD), 32'd0);
        checkOutput({tag, "_flushE"}, 32'(bus.oFlushE), 32'd0);
    endtask

    instr_t nop, add5, sub5, lui7, use7, lw0, use0, lw3, add3;
    instr_t table_q [$];

    initial begin
        checks   = 0;
        failures = 0;
        nop  = mk(0, 0, 0, 0, 0, 0);
        add5 = mk(1, 2, 5, 1, 0, 0);
        sub5 = mk(5, 6, 8, 1, 0, 0);
        lui7 = mk(0, 0, 7, 1, 0, 1);
        use7 = mk(1, 7, 9, 1, 0, 0);
        lw0  = mk(2, 0, 0, 1, 1, 0);
        use0 = mk(0, 0, 9, 1, 0, 0);
        lw3  = mk(2, 0, 3, 1, 1, 0);
        add3 = mk(3, 4, 4, 1, 0, 0);

        // Reset held with random decode inputs
        rst_n = 1'b0;
        driveD(nop, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #7;
            driveD(mk($urandom_range(31), $urandom_range(31), $urandom_range(31),
                      1'($urandom), 1'($urandom), 1'($urandom)), 1'b0);
            #1;
            checkAllQuiet("reset");
        end
        @(negedge clk);
        driveD(nop, 1'b0);
        #2 rst_n = 1'b1;
        applyStimulus(nop, 1'b0);
        checkOutput("first_fwd1", 32'(bus.oForwardAluOp1E), 32'd0);
        checkOutput("first_fwd2", 32'(bus.oForwardAluOp2E), 32'd0);

        // ALU RAW distance 1
        applyStimulus(add5, 1'b0);
        applyStimulus(sub5, 1'b0);
        applyStimulus(nop, 1'b0);
        checkOutput("raw_d1_fwd1", 32'(bus.oForwardAluOp1E), 32'd1);
        checkOutput("raw_d1_fwd2", 32'(bus.oForwardAluOp2E), 32'd0);
        applyStimulus(nop, 1'b0);
        applyStimulus(nop, 1'b0);

        // ALU RAW distance 2
        applyStimulus(add5, 1'b0);
        applyStimulus(nop, 1'b0);
        applyStimulus(sub5, 1'b0);
        applyStimulus(nop, 1'b0);
        checkOutput("raw_d2_fwd1", 32'(bus.oForwardAluOp1E), 32'd2);

        // Both M and W write x5: nearest wins
        applyStimulus(add5, 1'b0);
        applyStimulus(mk(0, 0, 5, 1, 0, 0), 1'b0);
        applyStimulus(sub5, 1'b0);
        applyStimulus(nop, 1'b0);
        checkOutput("raw_both_fwd1", 32'(bus.oForwardAluOp1E), 32'd1);
        applyStimulus(nop, 1'b0);
        applyStimulus(nop, 1'b0);

        // Upper forwarding at distance 1 and 2
        applyStimulus(lui7, 1'b0);
        applyStimulus(use7, 1'b0);
        applyStimulus(nop, 1'b0);
        checkOutput("upper_d1_fwd2", 32'(bus.oForwardAluOp2E), 32'd3);
        checkOutput("upper_d1_fwd1", 32'(bus.oForwardAluOp1E), 32'd0);
        applyStimulus(lui7, 1'b0);
        applyStimulus(nop, 1'b0);
        applyStimulus(use7, 1'b0);
        applyStimulus(nop, 1'b0);
        checkOutput("upper_d2_fwd2", 32'(bus.oForwardAluOp2E), 32'd3);
        applyStimulus(nop, 1'b0);
        applyStimulus(nop, 1'b0);

        // x0 guard: load to x0 never stalls or forwards
        applyStimulus(lw0, 1'b0);
        applyStimulus(use0, 1'b0);
        checkOutput("x0_stallF", 32'(bus.oStallF), 32'd0);
        checkOutput("x0_flushE", 32'(bus.oFlushE), 32'd0);
        applyStimulus(nop, 1'b0);
        checkOutput("x0_fwd1", 32'(bus.oForwardAluOp1E), 32'd0);
        applyStimulus(nop, 1'b0);
        applyStimulus(nop, 1'b0);

        // Reset asserted during a stall abandons it, no phantom forwards
        applyStimulus(lw3, 1'b0);
        applyStimulus(add3, 1'b0);
        checkOutput("midrst_pre_stallF", 32'(bus.oStallF), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkAllQuiet("midrst");
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(nop, 1'b0);
        checkOutput("midrst_post_fwd1", 32'(bus.oForwardAluOp1E), 32'd0);
        checkOutput("midrst_post_stallF", 32'(bus.oStallF), 32'd0);
        applyStimulus(nop, 1'b0);
        applyStimulus(nop, 1'b0);

        // Load-use: one bubble, then W forwarding
        applyStimulus(lw3, 1'b0);
        applyStimulus(add3, 1'b0);
        checkOutput("lu_stallF", 32'(bus.oStallF), 32'd1);
        checkOutput("lu_stallD", 32'(bus.oStallD), 32'd1);
        checkOutput("lu_flushE", 32'(bus.oFlushE), 32'd1);
        checkOutput("lu_flushD", 32'(bus.oFlushD), 32'd0);
        applyStimulus(add3, 1'b0);
        checkOutput("lu_after_stallF", 32'(bus.oStallF), 32'd0);
        checkOutput("lu_after_flushE", 32'(bus.oFlushE), 32'd0);
        applyStimulus(nop, 1'b0);
        checkOutput("lu_fwd1", 32'(bus.oForwardAluOp1E), 32'd2);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("lu_stallCnt", bus.oStallCnt, 32'd1);
        checkOutput("lu_flushCnt", bus.oFlushCnt, 32'd0);
`endif
        applyStimulus(nop, 1'b0);
        applyStimulus(nop, 1'b0);

        // Redirect coincident with load-use: redirect wins
        applyStimulus(lw3, 1'b0);
        applyStimulus(add3, 1'b1);
        checkOutput("rd_flushD", 32'(bus.oFlushD), 32'd1);
        checkOutput("rd_flushE", 32'(bus.oFlushE), 32'd1);
        checkOutput("rd_stallF", 32'(bus.oStallF), 32'd0);
        checkOutput("rd_stallD", 32'(bus.oStallD), 32'd0);
        applyStimulus(nop, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("rd_flushCnt", bus.oFlushCnt, 32'd1);
        checkOutput("rd_stallCnt", bus.oStallCnt, 32'd1);
`endif
        applyStimulus(nop, 1'b0);

        // Back-to-back loads and mixed traffic, stalls honoured by the driver
        table_q = '{mk(1, 0, 10, 1, 1, 0), mk(10, 0, 11, 1, 1, 0),
                    mk(11, 10, 12, 1, 0, 0), mk(12, 0, 13, 1, 0, 1),
                    mk(13, 12, 14, 1, 0, 0), mk(0, 13, 0, 1, 0, 0),
                    nop, nop};
        foreach (table_q[k]) begin
            applyStimulus(table_q[k], 1'b0);
            for (int guard = 0; guard < 4 && expStall(); guard++)
                applyStimulus(table_q[k], 1'b0);
        end
        applyStimulus(nop, 1'b0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
